// File: rtl/capp_search_ctrl_if.sv
// Command/response bus of the CAPP search controller.
//   cmd_*  : host -> controller commands (LOAD_CMP, LOAD_MASK, SEARCH, NEXT)
//   rsp_*  : controller -> host search/resolution results
// master = host side, slave = controller side.
interface capp_search_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 16
);
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CntW = $clog2(WORDS + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit;
  logic [IdxW-1:0]  rsp_index;
  logic [CntW-1:0]  rsp_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_index, rsp_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_hit, rsp_index, rsp_count
  );
endinterface

// File: rtl/capp_search_ctrl.sv
// Search sequencer for the content-addressable processor.
// Holds comparand/mask for the compare stage, pulses perform_search for SETTLE cycles,
// captures the word-cell tags and reports hit / first-match index / match count.
// NEXT clears the lowest set tag bit so matches are resolved lowest index first.
// Ports:
//   CLK, RST        : clock, asynchronous active-high reset
//   bus (slave)     : command and response handshakes
//   comparand, mask : registered operands to the compare stage
//   perform_search  : compare-stage enable, high during DRIVE
//   tags            : per-word match tags from the word cells
//   tag_vec         : held tag vector (captured, minus resolved bits)
module capp_search_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic                CLK,
  input  logic                RST,
  capp_search_ctrl_if.slave   bus,
  output logic [WIDTH-1:0]    comparand,
  output logic [WIDTH-1:0]    mask,
  output logic                perform_search,
  input  logic [WORDS-1:0]    tags,
  output logic [WORDS-1:0]    tag_vec
);
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CntW = $clog2(WORDS + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  localparam logic [1:0] OpLoadCmp  = 2'b00;
  localparam logic [1:0] OpLoadMask = 2'b01;
  localparam logic [1:0] OpSearch   = 2'b10;

  // Counter runs SETTLE-1 .. 0, one DRIVE cycle per count.
  localparam logic [3:0] CntInit = 4'(SETTLE - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] comparand_q, comparand_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WORDS-1:0] tag_vec_q, tag_vec_d;
  logic             perform_search_q, perform_search_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             hit_q, hit_d;
  logic [IdxW-1:0]  index_q, index_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             tag_upd;
  logic             cmd_fire;

  assign bus.cmd_ready = (state_q == StIdle) && !RST;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    comparand_d = comparand_q;
    mask_d      = mask_q;
    tag_vec_d   = tag_vec_q;
    tag_upd     = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          case (bus.cmd_op)
            OpLoadCmp:  comparand_d = bus.cmd_data;
            OpLoadMask: mask_d = bus.cmd_data;
            OpSearch: begin
              state_d = StDrive;
              cnt_d   = CntInit;
            end
            default: begin
              // NEXT: x & (x-1) clears the lowest set bit; zero stays zero.
              tag_vec_d = tag_vec_q & (tag_vec_q - WORDS'(1));
              tag_upd   = 1'b1;
              state_d   = StResp;
            end
          endcase
        end
      end
      StDrive: begin
        if (cnt_q == 4'd0) begin
          tag_vec_d = tags;
          tag_upd   = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Response fields derived from the tag vector being written this edge.
  always_comb begin
    hit_d   = |tag_vec_d;
    count_d = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      count_d = count_d + CntW'(tag_vec_d[i]);
    end
    index_d = '0;
    for (int i = int'(WORDS) - 1; i >= 0; i--) begin
      if (tag_vec_d[i]) index_d = IdxW'(i);
    end
  end

  assign perform_search_d = (state_d == StDrive);
  assign rsp_valid_d      = (state_d == StResp);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      comparand_q      <= '0;
      mask_q           <= '0;
      tag_vec_q        <= '0;
      perform_search_q <= 1'b0;
      rsp_valid_q      <= 1'b0;
      hit_q            <= 1'b0;
      index_q          <= '0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      comparand_q      <= comparand_d;
      mask_q           <= mask_d;
      tag_vec_q        <= tag_vec_d;
      perform_search_q <= perform_search_d;
      rsp_valid_q      <= rsp_valid_d;
      if (tag_upd) begin
        hit_q   <= hit_d;
        index_q <= index_d;
        count_q <= count_d;
      end
    end
  end

  assign comparand      = comparand_q;
  assign mask           = mask_q;
  assign perform_search = perform_search_q;
  assign tag_vec        = tag_vec_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = hit_q;
  assign bus.rsp_index  = index_q;
  assign bus.rsp_count  = count_q;
endmodule

// File: tb/tb_capp_search_ctrl.sv
module tb_capp_search_ctrl;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned WORDS  = 16;
  localparam int unsigned SETTLE = 2;

  localparam logic [1:0] OpLoadCmp  = 2'b00;
  localparam logic [1:0] OpLoadMask = 2'b01;
  localparam logic [1:0] OpSearch   = 2'b10;
  localparam logic [1:0] OpNext     = 2'b11;

  typedef struct packed {
    logic        hit;
    logic [3:0]  index;
    logic [4:0]  count;
    logic [15:0] tag;
  } rsp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  capp_search_ctrl_if #(.WIDTH(WIDTH), .WORDS(WORDS)) b  ();
  capp_search_ctrl_if #(.WIDTH(WIDTH), .WORDS(WORDS)) b1 ();

  logic [WIDTH-1:0] comparand, mask, comparand1, mask1;
  logic             perform_search, perform_search1;
  logic [WORDS-1:0] tags, tags1, tag_vec, tag_vec1;

  capp_search_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS), .SETTLE(SETTLE)) u_dut (
    .CLK            (CLK),
    .RST            (RST),
    .bus            (b),
    .comparand      (comparand),
    .mask           (mask),
    .perform_search (perform_search),
    .tags           (tags),
    .tag_vec        (tag_vec)
  );

  capp_search_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS), .SETTLE(1)) u_dut1 (
    .CLK            (CLK),
    .RST            (RST),
    .bus            (b1),
    .comparand      (comparand1),
    .mask           (mask1),
    .perform_search (perform_search1),
    .tags           (tags1),
    .tag_vec        (tag_vec1)
  );

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response transfer pops one expected entry.
  always @(negedge CLK) begin
    if (!RST && b.rsp_valid && b.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(b.rsp_valid), 64'(0));
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_hit",   64'(b.rsp_hit),   64'(e.hit));
        chk("rsp_index", 64'(b.rsp_index), 64'(e.index));
        chk("rsp_count", 64'(b.rsp_count), 64'(e.count));
        chk("tag_vec",   64'(tag_vec),     64'(e.tag));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents a command and returns one cycle after its accept edge.
  task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
    int n = 0;
    b.cmd_valid = 1'b1;
    b.cmd_op    = op;
    b.cmd_data  = data;
    while (!b.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!b.cmd_ready) chk("cmd_ready_wait", 64'(b.cmd_ready), 64'(1));
    tick();
    b.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_done();
    int n = 0;
    while (b.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("rsp_drop", 64'(b.rsp_valid), 64'(0));
  endtask

  task automatic do_search(input logic [15:0] t, input logic h, input logic [3:0] idx,
                           input logic [4:0] cnt);
    rsp_t e;
    e = '{hit: h, index: idx, count: cnt, tag: t};
    tags = t;
    exp_q.push_back(e);
    send_cmd(OpSearch, '0);
    for (int i = 0; i < int'(SETTLE); i++) begin
      chk("ps_drive", 64'(perform_search), 64'(1));
      chk("rv_drive", 64'(b.rsp_valid), 64'(0));
      tick();
    end
    chk("ps_after", 64'(perform_search), 64'(0));
    chk("rv_after", 64'(b.rsp_valid), 64'(1));
    wait_rsp_done();
  endtask

  task automatic do_next(input logic [15:0] t, input logic h, input logic [3:0] idx,
                         input logic [4:0] cnt);
    rsp_t e;
    e = '{hit: h, index: idx, count: cnt, tag: t};
    exp_q.push_back(e);
    send_cmd(OpNext, '0);
    chk("rv_next", 64'(b.rsp_valid), 64'(1));
    wait_rsp_done();
  endtask

  initial begin
    b.cmd_valid = 1'b0; b.cmd_op = '0; b.cmd_data = '0; b.rsp_ready = 1'b1;
    b1.cmd_valid = 1'b0; b1.cmd_op = '0; b1.cmd_data = '0; b1.rsp_ready = 1'b1;
    tags = '0; tags1 = 16'h0005;
    #12;
    chk("rst_cmd_ready", 64'(b.cmd_ready), 64'(0));
    chk("rst_comparand", 64'(comparand), 64'(0));
    chk("rst_mask", 64'(mask), 64'(0));
    chk("rst_ps", 64'(perform_search), 64'(0));
    chk("rst_rv", 64'(b.rsp_valid), 64'(0));
    chk("rst_tag_vec", 64'(tag_vec), 64'(0));
    chk("rst_count", 64'(b.rsp_count), 64'(0));
    RST = 1'b0;
    tick();
    chk("idle_ready", 64'(b.cmd_ready), 64'(1));

    // Back-to-back loads.
    b.cmd_valid = 1'b1; b.cmd_op = OpLoadCmp; b.cmd_data = 32'hA5A5_0000;
    tick();
    chk("load_cmp", 64'(comparand), 64'(32'hA5A5_0000));
    chk("load_ready0", 64'(b.cmd_ready), 64'(1));
    b.cmd_op = OpLoadMask; b.cmd_data = 32'hFFFF_0000;
    tick();
    chk("load_mask", 64'(mask), 64'(32'hFFFF_0000));
    chk("load_ready1", 64'(b.cmd_ready), 64'(1));
    chk("load_no_rsp", 64'(b.rsp_valid), 64'(0));
    b.cmd_valid = 1'b0;
    tick();

    // Search and multi-response resolution.
    do_search(16'h0050, 1'b1, 4'd4, 5'd2);
    do_next(16'h0040, 1'b1, 4'd6, 5'd1);
    do_next(16'h0000, 1'b0, 4'd0, 5'd0);
    do_next(16'h0000, 1'b0, 4'd0, 5'd0);
    chk("cmp_hold", 64'(comparand), 64'(32'hA5A5_0000));
    chk("mask_hold", 64'(mask), 64'(32'hFFFF_0000));

    // Backpressure: response held, command waits.
    b.rsp_ready = 1'b0;
    tags = 16'h0003;
    exp_q.push_back('{hit: 1'b1, index: 4'd0, count: 5'd2, tag: 16'h0003});
    send_cmd(OpSearch, '0);
    repeat (SETTLE) tick();
    b.cmd_valid = 1'b1; b.cmd_op = OpLoadCmp; b.cmd_data = 32'h1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", 64'(b.cmd_ready), 64'(0));
      chk("bp_rv", 64'(b.rsp_valid), 64'(1));
      chk("bp_count", 64'(b.rsp_count), 64'(2));
      chk("bp_hit", 64'(b.rsp_hit), 64'(1));
      chk("bp_cmp", 64'(comparand), 64'(32'hA5A5_0000));
      tick();
    end
    b.rsp_ready = 1'b1;
    send_cmd(OpLoadCmp, 32'h1);
    chk("bp_load", 64'(comparand), 64'(32'h1));

    // Edge cases.
    do_search(16'hFFFF, 1'b1, 4'd0, 5'd16);
    do_search(16'h0000, 1'b0, 4'd0, 5'd0);
    do_search(16'h8000, 1'b1, 4'd15, 5'd1);

    // Async reset during DRIVE.
    tags = 16'h00FF;
    send_cmd(OpSearch, '0);
    chk("pre_rst_ps", 64'(perform_search), 64'(1));
    #2 RST = 1'b1;
    #1;
    chk("arst_ps", 64'(perform_search), 64'(0));
    chk("arst_rv", 64'(b.rsp_valid), 64'(0));
    chk("arst_tag_vec", 64'(tag_vec), 64'(0));
    chk("arst_ready", 64'(b.cmd_ready), 64'(0));
    #3 RST = 1'b0;
    tick();
    chk("post_rst_ready", 64'(b.cmd_ready), 64'(1));
    do_search(16'h0050, 1'b1, 4'd4, 5'd2);

    // SETTLE = 1 instance: single-cycle perform_search.
    b1.cmd_valid = 1'b1; b1.cmd_op = OpSearch;
    tick();
    b1.cmd_valid = 1'b0;
    chk("s1_ps_high", 64'(perform_search1), 64'(1));
    chk("s1_rv_low", 64'(b1.rsp_valid), 64'(0));
    tick();
    chk("s1_ps_low", 64'(perform_search1), 64'(0));
    chk("s1_rv_high", 64'(b1.rsp_valid), 64'(1));
    chk("s1_count", 64'(b1.rsp_count), 64'(2));
    chk("s1_index", 64'(b1.rsp_index), 64'(0));
    tick();
    chk("s1_idle", 64'(b1.cmd_ready), 64'(1));

    repeat (3) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
